word_mem_be: RTL and testbench

//  Parametrised 1-write/1-read word-addressable memory with byte enables and explicit write/read enables.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/word_mem_be_if.sv | 35 +++
 rtl/mem_clear_seq.sv | 52 +++++
 rtl/word_mem_be.sv | 105 ++++++++++
 tb/tb_word_mem_be.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state type and byte-lane helpers for word_mem_be
// Contents:
//   state_t      clear-sweep FSM states
//   MAX_DATA_W   widest word the byte-merge helper handles
//   lanes()      byte lanes in a word of a given width
//   merge_bytes  old word with enabled byte lanes replaced by new data
package mem_pkg;

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   localparam int MAX_DATA_W = 512;
   localparam int MAX_LANES  = MAX_DATA_W / 8;

   function automatic int lanes(input int data_w);
      return data_w / 8;
   endfunction

   // Operands are zero-extended to MAX_DATA_W by the caller.
   // Disabled lanes keep the old byte.
   function automatic logic [MAX_DATA_W-1:0] merge_bytes(
      input logic [MAX_DATA_W-1:0] old_word,
      input logic [MAX_DATA_W-1:0] new_word,
      input logic [MAX_LANES-1:0]  be
   );
      logic [MAX_DATA_W-1:0] res;
      res = old_word;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/word_mem_be_if.sv
// rtl/word_mem_be_if.sv - access bus between a requester and word_mem_be
// Signals:
//   we, be, addr_w, data_in        write request (byte enables per lane)
//   re, addr_r                     read request
//   data_out, rd_valid             registered read data and its strobe
//   ready, err                     accepting accesses / out-of-range strobe
// Modports: master drives requests, slave is the memory.
interface word_mem_be_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   import mem_pkg::*;

   logic                        we;
   logic [lanes(DATA_W)-1:0]    be;
   logic [ADDR_W-1:0]           addr_w;
   logic [DATA_W-1:0]           data_in;
   logic                        re;
   logic [ADDR_W-1:0]           addr_r;
   logic [DATA_W-1:0]           data_out;
   logic                        rd_valid;
   logic                        ready;
   logic                        err;

   modport master (
      output we, be, addr_w, data_in, re, addr_r,
      input  data_out, rd_valid, ready, err
   );

   modport slave (
      input  we, be, addr_w, data_in, re, addr_r,
      output data_out, rd_valid, ready, err
   );

endinterface

// File: rtl/mem_clear_seq.sv
// rtl/mem_clear_seq.sv - post-reset clear sweep FSM for word_mem_be
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   ready        1 once the sweep is done (or at once when clearing is off)
//   clr_we       zero-write request for the word at clr_addr
//   clr_addr     word being cleared, counts 0..DEPTH-1
module mem_clear_seq
   import mem_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int DEPTH        = 1024,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   output logic              ready,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t state;

   // The edge that writes the last word also raises ready, so ready stays
   // low for exactly DEPTH cycles after reset is released.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
         ready    <= 1'b0;
         clr_we   <= CLEAR_ON_RST;
         clr_addr <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               if (clr_addr == LAST) begin
                  state  <= ST_READY;
                  ready  <= 1'b1;
                  clr_we <= 1'b0;
               end else begin
                  clr_addr <= clr_addr + ADDR_W'(1);
               end
            end
            default: begin
               ready  <= 1'b1;
               clr_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/word_mem_be.sv
// rtl/word_mem_be.sv - 1W/1R word memory with byte enables, registered read, clear sweep
// Ports:
//   clk, rst     clock, synchronous active-high reset (wins over any access)
//   bus          word_mem_be_if slave: write/read requests, data_out,
//                rd_valid, ready, err
// Parameters: DATA_W (multiple of 8), ADDR_W, DEPTH (1..2**ADDR_W),
//             BYPASS (1 write-first, 0 read-first), CLEAR_ON_RST.
module word_mem_be
   import mem_pkg::*;
#(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 10,
   parameter int DEPTH        = 1024,
   parameter bit BYPASS       = 1'b1,
   parameter bit CLEAR_ON_RST = 1'b1
) (
   input logic          clk,
   input logic          rst,
   word_mem_be_if.slave bus
);

   if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
      $error("word_mem_be: DATA_W must be a multiple of 8 within MAX_DATA_W");
   end
   if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
      $error("word_mem_be: DEPTH must lie in 1..2**ADDR_W");
   end

   // One extra bit so DEPTH == 2**ADDR_W compares correctly.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              ready;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;

   mem_clear_seq #(
      .ADDR_W       (ADDR_W),
      .DEPTH        (DEPTH),
      .CLEAR_ON_RST (CLEAR_ON_RST)
   ) u_clear (
      .clk      (clk),
      .rst      (rst),
      .ready    (ready),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   logic w_oob, r_oob, wr_go, rd_go, same_addr;
   assign w_oob     = {1'b0, bus.addr_w} >= DEPTH_X;
   assign r_oob     = {1'b0, bus.addr_r} >= DEPTH_X;
   assign wr_go     = ready & bus.we & ~w_oob;
   assign rd_go     = ready & bus.re;
   assign same_addr = bus.we & (bus.addr_w == bus.addr_r);

   // Single merge serves both the write path and the write-first bypass:
   // bypass only applies when addr_r == addr_w, so the old word is the same.
   logic [MAX_DATA_W-1:0] merge_full;
   logic [DATA_W-1:0]     merged;
   always_comb begin
      merge_full = merge_bytes(MAX_DATA_W'(mem[bus.addr_w]),
                               MAX_DATA_W'(bus.data_in),
                               MAX_LANES'(bus.be));
      merged     = merge_full[DATA_W-1:0];
   end
   if (DATA_W < MAX_DATA_W) begin : g_merge_hi
      logic unused_merge_hi;
      assign unused_merge_hi = ^merge_full[MAX_DATA_W-1:DATA_W];
   end

   // Clear writes and user writes never overlap: users are held off by ready.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we)     mem[clr_addr]   <= '0;
         else if (wr_go) mem[bus.addr_w] <= merged;
      end
   end

   logic [DATA_W-1:0] data_q;
   logic              rd_valid_q;
   logic              err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q     <= '0;
         rd_valid_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rd_valid_q <= rd_go;
         err_q      <= ready & ((bus.we & w_oob) | (bus.re & r_oob));
         if (rd_go) begin
            if (r_oob)                 data_q <= '0;
            else if (BYPASS && same_addr) data_q <= merged;
            else                       data_q <= mem[bus.addr_r];
         end
      end
   end

   assign bus.data_out = data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.err      = err_q;
   assign bus.ready    = ready;

endmodule

// File: tb/tb_word_mem_be.sv
// tb/tb_word_mem_be.sv - self-checking bench for word_mem_be (two configurations in lockstep)
// Instance a: DEPTH 1024, write-first. Instance b: DEPTH 1000, read-first.
module tb_word_mem_be;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   word_mem_be_if #(.DATA_W(32), .ADDR_W(10)) ifa ();
   word_mem_be_if #(.DATA_W(32), .ADDR_W(10)) ifb ();

   word_mem_be #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .BYPASS(1'b1), .CLEAR_ON_RST(1'b1))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   word_mem_be #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .BYPASS(1'b0), .CLEAR_ON_RST(1'b1))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));

   typedef struct {
      logic        rdv;
      logic [31:0] dout;
      logic        err;
      logic        rdy;
   } exp_t;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [9:0]  aw;
      logic [31:0] din;
      logic        re;
      logic [9:0]  ar;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic        err_a;
      logic        err_b;
   } vec_t;

   exp_t q_a[$];
   exp_t q_b[$];
   vec_t vt[20];

   int n_checks = 0;
   int n_errors = 0;

   int          m_depth[2] = '{1024, 1000};
   bit          m_byp[2]   = '{1'b1, 1'b0};
   logic [31:0] m_mem[2][1024];
   bit          m_ready[2];
   int          m_clr[2];
   logic [31:0] m_dout[2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] be);
      logic [31:0] mask;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   task automatic model_edge(input int k, input logic r, input logic we, input logic [3:0] be,
                             input logic [9:0] aw, input logic [31:0] din,
                             input logic re, input logic [9:0] ar, output exp_t e);
      bit woob, roob;
      e.rdv = 1'b0;
      e.err = 1'b0;
      if (r) begin
         m_ready[k] = 1'b0;
         m_clr[k]   = 0;
         m_dout[k]  = 32'h0;
      end else if (!m_ready[k]) begin
         m_mem[k][m_clr[k]] = 32'h0;
         if (m_clr[k] == m_depth[k] - 1) m_ready[k] = 1'b1;
         else m_clr[k]++;
      end else begin
         woob  = int'(aw) >= m_depth[k];
         roob  = int'(ar) >= m_depth[k];
         e.err = (we && woob) || (re && roob);
         if (re) begin
            e.rdv = 1'b1;
            if (roob) m_dout[k] = 32'h0;
            else if (m_byp[k] && we && aw == ar) m_dout[k] = ref_merge(m_mem[k][ar], din, be);
            else m_dout[k] = m_mem[k][ar];
         end
         if (we && !woob) m_mem[k][aw] = ref_merge(m_mem[k][aw], din, be);
      end
      e.dout = m_dout[k];
      e.rdy  = m_ready[k];
   endtask

   task automatic cyc(input logic r, input logic we, input logic [3:0] be, input logic [9:0] aw,
                      input logic [31:0] din, input logic re, input logic [9:0] ar);
      exp_t e;
      exp_t g;
      rst = r;
      ifa.we = we; ifa.be = be; ifa.addr_w = aw; ifa.data_in = din; ifa.re = re; ifa.addr_r = ar;
      ifb.we = we; ifb.be = be; ifb.addr_w = aw; ifb.data_in = din; ifb.re = re; ifb.addr_r = ar;
      model_edge(0, r, we, be, aw, din, re, ar, e);
      q_a.push_back(e);
      model_edge(1, r, we, be, aw, din, re, ar, e);
      q_b.push_back(e);
      @(posedge clk);
      #1;
      g = q_a.pop_front();
      chk("a_rd_valid", 32'(ifa.rd_valid), 32'(g.rdv));
      chk("a_err",      32'(ifa.err),      32'(g.err));
      chk("a_ready",    32'(ifa.ready),    32'(g.rdy));
      chk("a_data_out", ifa.data_out,      g.dout);
      g = q_b.pop_front();
      chk("b_rd_valid", 32'(ifb.rd_valid), 32'(g.rdv));
      chk("b_err",      32'(ifb.err),      32'(g.err));
      chk("b_ready",    32'(ifb.ready),    32'(g.rdy));
      chk("b_data_out", ifb.data_out,      g.dout);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
   endtask

   // Runs cycles (with optional ignored accesses) until both instances are
   // ready, recording the edge index at which each first shows ready=1.
   task automatic sweep(input logic busy, output int first_a, output int first_b);
      first_a = -1;
      first_b = -1;
      for (int n = 1; n <= 1100 && (first_a < 0 || first_b < 0); n++) begin
         cyc(1'b0, busy, 4'hF, 10'd0, 32'hFFFF_FFFF, busy, 10'd1);
         if (ifa.ready && first_a < 0) first_a = n;
         if (ifb.ready && first_b < 0) first_b = n;
      end
   endtask

   initial begin
      int fa, fb;

      vt[0]  = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b1, 10'd5,    32'h0,         32'h0,         1'b0, 1'b0};
      vt[1]  = '{1'b1, 4'hF, 10'd0,    32'hAAAA_BBBB, 1'b0, 10'd0,    32'h0,         32'h0,         1'b0, 1'b0};
      vt[2]  = '{1'b1, 4'hF, 10'd1,    32'h1234_5678, 1'b0, 10'd0,    32'h0,         32'h0,         1'b0, 1'b0};
      vt[3]  = '{1'b1, 4'hF, 10'd2,    32'hDEAD_BEEF, 1'b0, 10'd0,    32'h0,         32'h0,         1'b0, 1'b0};
      vt[4]  = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b1, 10'd0,    32'hAAAA_BBBB, 32'hAAAA_BBBB, 1'b0, 1'b0};
      vt[5]  = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b1, 10'd1,    32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0};
      vt[6]  = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b1, 10'd2,    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0};
      vt[7]  = '{1'b1, 4'h3, 10'd1,    32'hFFFF_0000, 1'b0, 10'd0,    32'h0,         32'h0,         1'b0, 1'b0};
      vt[8]  = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b1, 10'd1,    32'h1234_0000, 32'h1234_0000, 1'b0, 1'b0};
      vt[9]  = '{1'b1, 4'h0, 10'd1,    32'h5555_5555, 1'b0, 10'd0,    32'h0,         32'h0,         1'b0, 1'b0};
      vt[10] = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b1, 10'd1,    32'h1234_0000, 32'h1234_0000, 1'b0, 1'b0};
      vt[11] = '{1'b1, 4'hF, 10'd2,    32'h0102_0304, 1'b1, 10'd2,    32'h0102_0304, 32'hDEAD_BEEF, 1'b0, 1'b0};
      vt[12] = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b1, 10'd2,    32'h0102_0304, 32'h0102_0304, 1'b0, 1'b0};
      vt[13] = '{1'b1, 4'hF, 10'd1010, 32'h0000_0099, 1'b0, 10'd0,    32'h0,         32'h0,         1'b0, 1'b1};
      vt[14] = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b1, 10'd1010, 32'h0000_0099, 32'h0,         1'b0, 1'b1};
      vt[15] = '{1'b1, 4'hF, 10'd1000, 32'h0000_0077, 1'b1, 10'd1023, 32'h0,         32'h0,         1'b0, 1'b1};
      vt[16] = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b0, 10'd0,    32'h0,         32'h0,         1'b0, 1'b0};
      vt[17] = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b1, 10'd999,  32'h0,         32'h0,         1'b0, 1'b0};
      vt[18] = '{1'b1, 4'hA, 10'd3,    32'h1122_3344, 1'b1, 10'd3,    32'h1100_3300, 32'h0,         1'b0, 1'b0};
      vt[19] = '{1'b0, 4'h0, 10'd0,    32'h0,         1'b1, 10'd3,    32'h1100_3300, 32'h1100_3300, 1'b0, 1'b0};

      // Reset for two cycles with accesses requested: reset must win.
      cyc(1'b1, 1'b1, 4'hF, 10'd5, 32'hFFFF_FFFF, 1'b1, 10'd5);
      cyc(1'b1, 1'b1, 4'hF, 10'd5, 32'hFFFF_FFFF, 1'b1, 10'd5);
      chk("rst_ready_a", 32'(ifa.ready), 32'h0);
      chk("rst_data_a",  ifa.data_out,   32'h0);

      sweep(1'b0, fa, fb);
      chk("sweep_len_a", 32'(fa), 32'd1024);
      chk("sweep_len_b", 32'(fb), 32'd1000);

      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, vt[i].we, vt[i].be, vt[i].aw, vt[i].din, vt[i].re, vt[i].ar);
         chk($sformatf("tbl%0d_err_a", i), 32'(ifa.err), 32'(vt[i].err_a));
         chk($sformatf("tbl%0d_err_b", i), 32'(ifb.err), 32'(vt[i].err_b));
         if (vt[i].re) begin
            chk($sformatf("tbl%0d_data_a", i), ifa.data_out, vt[i].exp_a);
            chk($sformatf("tbl%0d_data_b", i), ifb.data_out, vt[i].exp_b);
         end
      end

      // Error pulse lasts one cycle only.
      idle();
      chk("err_clears_b", 32'(ifb.err), 32'h0);

      // Reset mid-sweep at address 300 restarts the sweep from zero.
      cyc(1'b1, 1'b0, 4'h0, 10'd0, 32'h0, 1'b0, 10'd0);
      for (int n = 0; n < 300; n++) begin
         cyc(1'b0, 1'b1, 4'hF, 10'd0, 32'hFFFF_FFFF, 1'b1, 10'd1);
         if (ifa.rd_valid || ifa.err) chk("clear_ignores_access", 32'(ifa.rd_valid), 32'h0);
      end
      cyc(1'b1, 1'b1, 4'hF, 10'd0, 32'hFFFF_FFFF, 1'b1, 10'd1);
      sweep(1'b1, fa, fb);
      chk("restart_len_a", 32'(fa), 32'd1024);
      chk("restart_len_b", 32'(fb), 32'd1000);

      cyc(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd0);
      chk("post_clear_a0", ifa.data_out, 32'h0);
      cyc(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd1010);
      chk("post_clear_a1010", ifa.data_out, 32'h0);
      cyc(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 10'd2);
      chk("post_clear_b2", ifb.data_out, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
